thermal_plant: RTL and testbench

Closed-loop plant model for the temperature controller: consumes the controller's `heater`, `cooler` and `rps` outputs and produces the signed 8-bit `sensor` reading the controller samples. It integrates actuator effort and ambient drift once per update period, with saturation. It also flags illegal simultaneous heat/cool requests. It sits opposite the controller in system-level benches and drives the controller's `sensor` input directly.

---
 rtl/thermal_plant_if.sv | 22 ++
 rtl/thermal_plant.sv | 118 +++++++++++
 tb/tb_thermal_plant.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/thermal_plant_if.sv
// Actuator/sensor bundle between the temperature controller and the plant model.
// The controller side (master) drives the actuators and ambient; the plant side
// (slave) returns the temperature reading, update pulse and fault flag.
interface thermal_plant_if;
  logic              heater;
  logic              cooler;
  logic [3:0]        rps;
  logic signed [7:0] ambient;
  logic signed [7:0] sensor;
  logic              tick;
  logic              fault;

  modport master (
    output heater, cooler, rps, ambient,
    input  sensor, tick, fault
  );

  modport slave (
    input  heater, cooler, rps, ambient,
    output sensor, tick, fault
  );
endinterface

// File: rtl/thermal_plant.sv
// Closed-loop thermal plant model. A mode FSM tracks the actuator requests
// every cycle; once per TICK_CYCLES the temperature integrates heating,
// fan-proportional cooling or ambient drift, saturated to the signed 8-bit range.
module thermal_plant #(
  parameter int                TICK_CYCLES = 4,
  parameter int                HEAT_STEP   = 2,
  parameter int                COOL_GAIN   = 1,
  parameter logic signed [7:0] INIT_TEMP   = 8'sd20,
  parameter bit                DRIFT_EN    = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  thermal_plant_if.slave pif
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int ACC_W = 13;

  localparam logic signed [ACC_W-1:0] MAX_T  = 13'sd127;
  localparam logic signed [ACC_W-1:0] MIN_T  = -13'sd128;
  localparam logic signed [ACC_W-1:0] ONE    = 13'sd1;
  localparam logic signed [ACC_W-1:0] HEAT_X = ACC_W'(HEAT_STEP);
  localparam logic        [ACC_W-1:0] GAIN_X = ACC_W'(COOL_GAIN);
  localparam logic        [CNT_W-1:0] LAST   = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} mode_t;

  mode_t             state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wrap;
  logic signed [7:0] temp_q, temp_d;
  logic              tick_q;
  logic              fault_q;

  // Clamp a wide signed result into -128..+127; the reading never wraps.
  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > MAX_T)      return 8'sd127;
    else if (v < MIN_T) return -8'sd128;
    else                return v[7:0];
  endfunction

  // Unsaturated next temperature for the mode held during the closing cycle.
  function automatic logic signed [ACC_W-1:0] step(
    input mode_t             m,
    input logic signed [7:0] t,
    input logic        [3:0] r,
    input logic signed [7:0] amb
  );
    logic signed [ACC_W-1:0] t_x;
    logic        [ACC_W-1:0] cool_u;
    t_x    = {{(ACC_W-8){t[7]}}, t};
    cool_u = GAIN_X * {{(ACC_W-4){1'b0}}, r};
    case (m)
      HEAT:    return t_x + HEAT_X;
      COOL:    return t_x - $signed(cool_u);
      IDLE: begin
        if (!DRIFT_EN)     return t_x;
        else if (t < amb)  return t_x + ONE;
        else if (t > amb)  return t_x - ONE;
        else               return t_x;
      end
      default: return t_x;
    endcase
  endfunction

  // Mode decode: the next mode depends only on the current request pair.
  always_comb begin
    state_d = IDLE;
    case ({pif.heater, pif.cooler})
      2'b10:   state_d = HEAT;
      2'b01:   state_d = COOL;
      2'b11:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Mode register with the fault flag registered alongside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= (state_d == FAULT);
    end
  end

  assign wrap = (cnt_q == LAST);

  // Update-period counter; reset discards any partial period.
  always_ff @(posedge clock) begin
    if (reset)     cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Candidate temperature, using the pre-edge mode so a simultaneous mode
  // change cannot influence the update it coincides with.
  always_comb begin
    temp_d = sat8(step(state_q, temp_q, pif.rps, pif.ambient));
  end

  // --- update stage: temperature and tick change together on the wrap edge ---
  always_ff @(posedge clock) begin
    if (reset) begin
      temp_q <= INIT_TEMP;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (wrap) temp_q <= temp_d;
    end
  end

  assign pif.sensor = temp_q;
  assign pif.tick   = tick_q;
  assign pif.fault  = fault_q;

endmodule

// File: tb/tb_thermal_plant.sv
// Bench for thermal_plant: directed scenarios plus randomized actuator traffic
// on a default instance checked by a scoreboard, and two saturation instances.
module tb_thermal_plant;

  logic clock = 1'b0;
  logic rst_a;
  logic rst_s;

  always #5 clock = ~clock;

  thermal_plant_if ifa ();
  thermal_plant_if ifb ();
  thermal_plant_if ifc ();

  thermal_plant dut_a (.clock(clock), .reset(rst_a), .pif(ifa.slave));

  thermal_plant #(.INIT_TEMP(8'sd126)) dut_b (
    .clock(clock), .reset(rst_s), .pif(ifb.slave));

  thermal_plant #(.INIT_TEMP(-8'sd120), .COOL_GAIN(10)) dut_c (
    .clock(clock), .reset(rst_s), .pif(ifc.slave));

  int errors = 0;
  int checks = 0;
  bit sat_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic from the plant's rules.
  function automatic int clamp(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int model_update(input bit h, input bit c, input int rps,
                                      input int amb, input int t);
    if (h && c)  return t;
    if (h)       return clamp(t + 2);
    if (c)       return clamp(t - rps);
    if (t < amb) return t + 1;
    if (t > amb) return t - 1;
    return t;
  endfunction

  int m_temp  = 20;
  int m_edges = 0;
  bit m_ph    = 1'b0;
  bit m_pc    = 1'b0;
  bit m_tick  = 1'b0;
  bit m_fault = 1'b0;
  int exp_q[$];

  // Model: every TICK edges since reset, apply the request pair that was
  // sampled on the previous edge; push the expected reading for the monitor.
  initial forever begin
    @(posedge clock);
    if (rst_a) begin
      m_temp = 20; m_edges = 0; m_ph = 1'b0; m_pc = 1'b0;
      m_tick = 1'b0; m_fault = 1'b0;
      exp_q.delete();
    end else begin
      m_edges++;
      m_tick = 1'b0;
      if (m_edges % 4 == 0) begin
        m_temp = model_update(m_ph, m_pc, int'(ifa.rps), int'(ifa.ambient), m_temp);
        exp_q.push_back(m_temp);
        m_tick = 1'b1;
      end
      m_ph    = ifa.heater;
      m_pc    = ifa.cooler;
      m_fault = m_ph && m_pc;
    end
  end

  // Monitor: per-cycle flags, and a popped expected reading on each tick.
  initial forever begin
    @(negedge clock);
    check("tick", int'(ifa.tick), int'(m_tick));
    check("fault", int'(ifa.fault), int'(m_fault));
    check("sensor_hold", int'(ifa.sensor), m_temp);
    if (ifa.tick) begin
      if (exp_q.size() == 0) begin
        check("sensor_unexpected_tick", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sensor_update", int'(ifa.sensor), e);
      end
    end
  end

  task automatic wait_tick(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (ifa.tick) begin
        lat = i;
        break;
      end
    end
  endtask

  // Saturation instances run alongside the main sequence.
  initial begin
    rst_s = 1'b1;
    ifb.heater = 1'b1; ifb.cooler = 1'b0; ifb.rps = 4'd0;  ifb.ambient = 8'sd0;
    ifc.heater = 1'b0; ifc.cooler = 1'b1; ifc.rps = 4'd15; ifc.ambient = 8'sd0;
    repeat (2) @(negedge clock);
    rst_s = 1'b0;
    repeat (4) @(negedge clock);
    check("sat_hi_1", int'(ifb.sensor), 127);
    check("sat_lo_1", int'(ifc.sensor), -128);
    check("sat_tick", int'(ifb.tick), 1);
    repeat (4) @(negedge clock);
    check("sat_hi_2", int'(ifb.sensor), 127);
    check("sat_lo_2", int'(ifc.sensor), -128);
    sat_done = 1'b1;
  end

  // Main stimulus.
  initial begin
    int lat;
    int hold;
    int sel;
    rst_a = 1'b1;
    ifa.heater = 1'b1; ifa.cooler = 1'b0; ifa.rps = 4'd0; ifa.ambient = 8'sd20;
    repeat (3) @(negedge clock);
    check("reset_sensor", int'(ifa.sensor), 20);
    rst_a = 1'b0;

    // Heating: 22, 24, 26
    wait_tick(lat);
    check("first_tick_latency", lat, 4);
    repeat (8) @(negedge clock);
    check("heat_3_periods", int'(ifa.sensor), 26);

    // Cooling at rps 5: 21, 16; then rps 0 holds
    ifa.heater = 1'b0; ifa.cooler = 1'b1; ifa.rps = 4'd5;
    repeat (8) @(negedge clock);
    check("cool_2_periods", int'(ifa.sensor), 16);
    ifa.rps = 4'd0;
    repeat (4) @(negedge clock);
    check("cool_rps0_hold", int'(ifa.sensor), 16);

    // Fault from 20
    rst_a = 1'b1;
    @(negedge clock);
    rst_a = 1'b0;
    ifa.heater = 1'b1; ifa.cooler = 1'b1;
    @(negedge clock);
    check("fault_rise", int'(ifa.fault), 1);
    repeat (7) @(negedge clock);
    check("fault_hold_temp", int'(ifa.sensor), 20);
    ifa.heater = 1'b0; ifa.cooler = 1'b0; ifa.ambient = -8'sd5;
    @(negedge clock);
    check("fault_fall", int'(ifa.fault), 0);

    // Drift toward -5, then held
    repeat (110) @(negedge clock);
    check("drift_settled", int'(ifa.sensor), -5);

    // Reset two cycles into a period
    wait_tick(lat);
    check("period_align", lat > 0 ? 1 : 0, 1);
    repeat (2) @(negedge clock);
    rst_a = 1'b1;
    @(negedge clock);
    rst_a = 1'b0;
    check("mid_reset_sensor", int'(ifa.sensor), 20);
    wait_tick(lat);
    check("mid_reset_tick_latency", lat, 4);

    // Randomized traffic
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        sel = int'($urandom_range(0, 9));
        ifa.heater  = (sel < 3) || (sel == 9);
        ifa.cooler  = (sel >= 3 && sel < 6) || (sel == 9);
        ifa.rps     = 4'($urandom_range(0, 15));
        ifa.ambient = 8'($urandom_range(0, 255));
        hold        = int'($urandom_range(1, 8));
      end
      hold--;
      rst_a = ($urandom_range(0, 59) == 0);
      @(negedge clock);
    end
    rst_a = 1'b0;
    repeat (6) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    for (int i = 0; i < 50 && !sat_done; i++) @(negedge clock);
    check("sat_done", int'(sat_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
